// File: rtl/game_pkg.sv
// Shared constants and types for the falling-piece controller.
package game_pkg;

    localparam int unsigned COORD_W       = 12;
    localparam int unsigned SHAPE_W       = 3;
    localparam int unsigned ROT_W         = 3;
    localparam int unsigned SHAPE_COUNT   = 7;
    localparam int unsigned LFSR_W        = $clog2(SHAPE_COUNT + 1);
    localparam int unsigned CELL_PX       = 32;
    localparam int unsigned FIELD_X_MIN   = 0;
    localparam int unsigned FIELD_X_MAX   = 992;
    localparam int unsigned FIELD_Y_MAX   = 736;
    localparam int unsigned FIELD_SPAWN_X = 480;

    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_FALL  = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
    } req_t;

    // x^3 + x^2 + 1, shifting left; never reaches zero from a non-zero seed
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[1:0], v[2] ^ v[1]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, level debouncer and registered rising-edge pulse for one button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 750000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/block_fall_ctl.sv
// Active-piece sequencer: spawn, per-frame moves/rotation, gravity, floor landing and lock delay.
module block_fall_ctl
    import game_pkg::*;
#(
    parameter int unsigned CELL            = CELL_PX,
    parameter int unsigned X_MIN           = FIELD_X_MIN,
    parameter int unsigned X_MAX           = FIELD_X_MAX,
    parameter int unsigned Y_MAX           = FIELD_Y_MAX,
    parameter int unsigned SPAWN_X         = FIELD_SPAWN_X,
    parameter int unsigned GRAVITY_FRAMES  = 30,
    parameter int unsigned LOCK_FRAMES     = 15,
    parameter int unsigned DEBOUNCE_CYCLES = 750000
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               btnL,
    input  logic               btnR,
    input  logic               btnD,
    input  logic               btnU,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic [SHAPE_W-1:0] block,
    output logic [ROT_W-1:0]   rot,
    output logic               landed
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam int unsigned GW  = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam int unsigned LW  = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

    logic [3:0] btn_raw, btn_level, btn_rise;
    logic       unused_btn;

    assign btn_raw = {btnU, btnD, btnR, btnL};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (pclk),
            .rst_n  (rst),
            .btn_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .rise_o (btn_rise[i])
        );
    end

    // Down is consumed as a level; the other three as edges.
    assign unused_btn = ^{btn_level[3], btn_level[1:0], btn_rise[2]};

    logic                d_level;
    logic [1:0]          vs_q;
    logic                tick_q;
    logic [LFSR_W-1:0]   lfsr_q;

    assign d_level = btn_level[2];

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vs_q   <= '0;
            tick_q <= 1'b0;
            lfsr_q <= LFSR_SEED;
        end else begin
            vs_q   <= {vs_q[0], vsync_in};
            tick_q <= vs_q[0] & ~vs_q[1];
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    state_e             state_q, state_d;
    logic [COORD_W-1:0] xpos_q, xpos_d;
    logic [COORD_W-1:0] ypos_q, ypos_d;
    logic [SHAPE_W-1:0] block_q, block_d;
    logic [ROT_W-1:0]   rot_q, rot_d;
    logic [GW-1:0]      grav_q, grav_d;
    logic [LW-1:0]      lock_q, lock_d;
    req_t               req_q, req_d;
    logic               landed_q, landed_d;

    logic grav_step, y_fits, lock_done, can_left, can_right;

    assign grav_step = d_level || (grav_q == GW'(GRAVITY_FRAMES - 1));
    assign lock_done = (lock_q == LW'(LOCK_FRAMES - 1));
    // Bounds are checked one bit wider so the add never wraps.
    assign y_fits    = ({1'b0, ypos_q} + CW1'(CELL)) <= CW1'(Y_MAX);
    assign can_left  = {1'b0, xpos_q} >= CW1'(X_MIN + CELL);
    assign can_right = ({1'b0, xpos_q} + CW1'(CELL)) <= CW1'(X_MAX);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SPAWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SPAWN: state_d = ST_FALL;
            ST_FALL:  if (tick_q && grav_step && !y_fits) state_d = ST_LOCK;
            ST_LOCK:  if (tick_q && lock_done) state_d = ST_SPAWN;
            default:  state_d = ST_SPAWN;
        endcase
    end

    always_comb begin
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        block_d  = block_q;
        rot_d    = rot_q;
        grav_d   = grav_q;
        lock_d   = lock_q;
        landed_d = 1'b0;
        // Flags drop on the tick, but an edge landing on the tick cycle survives to the next frame.
        req_d       = tick_q ? '0 : req_q;
        req_d.left  = req_d.left  | btn_rise[0];
        req_d.right = req_d.right | btn_rise[1];
        req_d.up    = req_d.up    | btn_rise[3];

        if (tick_q && (state_q == ST_FALL || state_q == ST_LOCK)) begin
            if (req_q.left && !req_q.right && can_left) begin
                xpos_d = xpos_q - COORD_W'(CELL);
            end else if (req_q.right && !req_q.left && can_right) begin
                xpos_d = xpos_q + COORD_W'(CELL);
            end
        end

        case (state_q)
            ST_SPAWN: begin
                xpos_d  = COORD_W'(SPAWN_X);
                ypos_d  = '0;
                rot_d   = '0;
                block_d = SHAPE_W'(lfsr_q - LFSR_W'(1));
                grav_d  = '0;
                lock_d  = '0;
                req_d   = '0;
            end
            ST_FALL: begin
                if (tick_q) begin
                    if (req_q.up) begin
                        rot_d = {1'b0, rot_q[1:0] + 2'd1};
                    end
                    if (grav_step) begin
                        grav_d = '0;
                        lock_d = '0;
                        if (y_fits) begin
                            ypos_d = ypos_q + COORD_W'(CELL);
                        end
                    end else begin
                        grav_d = grav_q + GW'(1);
                    end
                end
            end
            ST_LOCK: begin
                if (tick_q) begin
                    if (lock_done) begin
                        landed_d = 1'b1;
                        lock_d   = '0;
                    end else begin
                        lock_d = lock_q + LW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            xpos_q   <= COORD_W'(SPAWN_X);
            ypos_q   <= '0;
            block_q  <= '0;
            rot_q    <= '0;
            grav_q   <= '0;
            lock_q   <= '0;
            req_q    <= '0;
            landed_q <= 1'b0;
        end else begin
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            block_q  <= block_d;
            rot_q    <= rot_d;
            grav_q   <= grav_d;
            lock_q   <= lock_d;
            req_q    <= req_d;
            landed_q <= landed_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign block  = block_q;
    assign rot    = rot_q;
    assign landed = landed_q;

endmodule
